// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: BCD width, digit-enable decode and AN polarity.
package seg_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam int unsigned MaxDigits = 8;

  // One-hot enable for digit idx out of n; all-zero if idx is out of range.
  function automatic logic [MaxDigits-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MaxDigits-1:0] v;
    v = '0;
    if (idx < n) v = MaxDigits'(1) << idx;
    return v;
  endfunction

  function automatic logic [MaxDigits-1:0] an_drive(input logic [MaxDigits-1:0] en,
                                                    input bit active_low);
    return active_low ? ~en : en;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Data-in / display-out bundle of the scan driver; master drives data, slave is the driver.
interface seg_scan_driver_if
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic                          load;
  logic [BCD_W*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]         dp_mask;
  logic                          blank_en;
  logic [NUM_DIGITS-1:0]         AN;
  logic [BCD_W-1:0]              seg_code;
  logic                          point;
  logic                          frame_done;

  modport master (
    output load, digits_in, dp_mask, blank_en,
    input  AN, seg_code, point, frame_done
  );

  modport slave (
    input  load, digits_in, dp_mask, blank_en,
    output AN, seg_code, point, frame_done
  );

endinterface

// File: rtl/scan_prescaler.sv
// Slot timer: counts 0..CLK_DIV-1, flags the last cycle of each slot and the leading dead window.
module scan_prescaler #(
  parameter int unsigned CLK_DIV     = 100000,
  parameter int unsigned DEAD_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic slot_tick_o,
  output logic in_dead_o
);

  localparam int unsigned     CntW   = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign slot_tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (slot_tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign in_dead_o = 1'b0;
  end else begin : g_dead
    assign in_dead_o = (32'(cnt_q) < DEAD_CYCLES);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous data update,
// leading-zero blanking and optional anti-ghost dead time.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned CLK_DIV       = 100000,
  parameter int unsigned DEAD_CYCLES   = 0,
  parameter bit          AN_ACTIVE_LOW = 1'b0,
  parameter bit          LZ_BLANK      = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam int unsigned DataW = BCD_W * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] AnReset =
    NUM_DIGITS'(an_drive(onehot(0, NUM_DIGITS), AN_ACTIVE_LOW));

  logic slot_tick, in_dead, frame_end;

  scan_prescaler #(
    .CLK_DIV     (CLK_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_prescaler (
    .clk_i       (clk),
    .rst_i       (rst),
    .slot_tick_o (slot_tick),
    .in_dead_o   (in_dead)
  );

  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DataW-1:0]      pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [BCD_W-1:0]      seg_q, seg_d;
  logic                  point_q, point_d;

  assign frame_end = slot_tick && (idx_q == IdxW'(NUM_DIGITS - 1));

  always_comb begin
    idx_d = idx_q;
    if (slot_tick) idx_d = frame_end ? '0 : idx_q + IdxW'(1);
  end

  // Active data only changes on the frame boundary so a frame never mixes two loads.
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    if (frame_end) begin
      if (bus.load) begin
        act_digits_d = bus.digits_in;
        act_dp_d     = bus.dp_mask;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end else if (bus.load) begin
      pend_digits_d = bus.digits_in;
      pend_dp_d     = bus.dp_mask;
      pend_valid_d  = 1'b1;
    end
  end

  // Digit i is blankable when it and every more-significant digit are zero with no DP lit.
  logic [NUM_DIGITS-1:0] blank;
  always_comb begin
    blank = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      blank[i] = ((act_digits_q >> (BCD_W * i)) == '0) && ((act_dp_q >> i) == '0);
    end
  end

  logic                  blanked, cur_dp;
  logic [BCD_W-1:0]      cur_digit;
  logic [NUM_DIGITS-1:0] en_vec;

  always_comb begin
    cur_digit = BCD_W'(act_digits_q >> (BCD_W * idx_q));
    cur_dp    = act_dp_q[idx_q];
    blanked   = LZ_BLANK && bus.blank_en && blank[idx_q];
    en_vec    = NUM_DIGITS'(onehot(32'(idx_q), NUM_DIGITS));
    if (blanked || in_dead) en_vec = '0;
    an_d      = NUM_DIGITS'(an_drive(MaxDigits'(en_vec), AN_ACTIVE_LOW));
    seg_d     = blanked ? '0 : cur_digit;
    point_d   = !blanked && cur_dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      an_q          <= AnReset;
      seg_q         <= '0;
      point_q       <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      point_q       <= point_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.seg_code   = seg_q;
  assign bus.point      = point_q;
  assign bus.frame_done = frame_end;

endmodule
